// File: rtl/paridade_pkg.sv
// -----------------------------------------------------------------------------
// paridade_pkg
// Shared definitions for the 4-bit even/odd parity serial link.
//   estado_t       : receiver FSM state encoding (OCIOSO..PARADA)
//   N_DADOS        : number of data bits per frame
//   calc_paridade  : parity bit for a nibble. It is also used by the
//                    transmitter, so both ends agree on the rule.
// -----------------------------------------------------------------------------
package paridade_pkg;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    PARADA   = 3'd4
  } estado_t;

  localparam int N_DADOS = 4;

  // impar = 0 gives even parity (p = a3^a2^a1^a0). impar = 1 inverts it.
  function automatic logic calc_paridade(input logic [N_DADOS-1:0] nibble,
                                         input logic               impar);
    return (^nibble) ^ impar;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// -----------------------------------------------------------------------------
// sincronizador_2ff
// Two-flop synchronizer for a single asynchronous input. Both flops reset to
// 1 so that an idle-high serial line does not look like a start bit right
// after reset.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   d_in   in  asynchronous input
//   d_out  out synchronized input (second flop)
// -----------------------------------------------------------------------------
module sincronizador_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic d_out
);

  logic meta_q, meta_d;
  logic sinc_q, sinc_d;

  always_comb begin
    meta_d = d_in;
    sinc_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sinc_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sinc_q <= sinc_d;
    end
  end

  assign d_out = sinc_q;

endmodule

// File: rtl/receptor_paridade_serial.sv
// -----------------------------------------------------------------------------
// receptor_paridade_serial
// UART-style receiver for the 4-bit parity link. A frame is:
//   start(0), a0, a1, a2, a3, parity, stop(1)
// Each bit lasts CLKS_POR_BIT clocks. Each bit is sampled at its middle.
// Parameters:
//   CLKS_POR_BIT    clocks per serial bit (even, >= 4)
//   PARIDADE_IMPAR  0 = even parity, 1 = odd parity
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   rx             in   serial line, idle high, asynchronous to clk
//   dado           out  last received nibble {a3,a2,a1,a0}
//   valido         out  one-cycle strobe when a frame completes
//   erro_paridade  out  parity mismatch for the frame flagged by valido
//   erro_quadro    out  stop bit sampled low for the frame flagged by valido
//   ocupado        out  FSM is outside OCIOSO
// Handshake: valido is a one-cycle strobe with no backpressure.
// dado, erro_paridade and erro_quadro are valid in the cycle valido is high.
// They hold their values until the next frame completes.
// -----------------------------------------------------------------------------
module receptor_paridade_serial
  import paridade_pkg::*;
#(
  parameter int CLKS_POR_BIT   = 16,
  parameter int PARIDADE_IMPAR = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx,
  output logic [N_DADOS-1:0] dado,
  output logic               valido,
  output logic               erro_paridade,
  output logic               erro_quadro,
  output logic               ocupado
);

  localparam int                CNT_W      = $clog2(CLKS_POR_BIT);
  localparam logic [CNT_W-1:0]  CNT_ULTIMO = CNT_W'(CLKS_POR_BIT - 1);
  // From the first low sample to the middle of the start bit.
  localparam logic [CNT_W-1:0]  CNT_MEIO   = CNT_W'(CLKS_POR_BIT / 2 - 1);
  localparam logic [1:0]        IDX_ULTIMO = 2'(N_DADOS - 1);
  localparam logic              IMPAR      = (PARIDADE_IMPAR != 0);

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic rx_s;

  sincronizador_2ff u_sinc (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (rx),
    .d_out (rx_s)
  );

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  estado_t              estado_q, estado_d;
  logic [CNT_W-1:0]     cnt_clk_q, cnt_clk_d;
  logic [1:0]           idx_bit_q, idx_bit_d;
  logic [N_DADOS-1:0]   shift_q, shift_d;
  logic                 p_rx_q, p_rx_d;
  logic                 esperado_q, esperado_d;
  logic [N_DADOS-1:0]   dado_q, dado_d;
  logic                 valido_q, valido_d;
  logic                 erro_paridade_q, erro_paridade_d;
  logic                 erro_quadro_q, erro_quadro_d;
  logic                 ocupado_q, ocupado_d;

  // Helpers for the one-bit-period counter used by DADOS/PARIDADE/PARADA.
  logic                 fim_bit;
  logic [CNT_W-1:0]     cnt_prox;

  always_comb begin
    estado_d        = estado_q;
    cnt_clk_d       = cnt_clk_q;
    idx_bit_d       = idx_bit_q;
    shift_d         = shift_q;
    p_rx_d          = p_rx_q;
    esperado_d      = esperado_q;
    dado_d          = dado_q;
    valido_d        = 1'b0;
    erro_paridade_d = erro_paridade_q;
    erro_quadro_d   = erro_quadro_q;

    fim_bit  = (cnt_clk_q == CNT_ULTIMO);
    cnt_prox = fim_bit ? '0 : cnt_clk_q + 1'b1;

    case (estado_q)
      OCIOSO: begin
        cnt_clk_d = '0;
        if (!rx_s) begin
          estado_d = INICIO;
        end
      end

      INICIO: begin
        if (cnt_clk_q == CNT_MEIO) begin
          cnt_clk_d = '0;
          // A line that is high again at mid start bit was a glitch.
          if (rx_s) begin
            estado_d = OCIOSO;
          end else begin
            estado_d  = DADOS;
            idx_bit_d = '0;
          end
        end else begin
          cnt_clk_d = cnt_clk_q + 1'b1;
        end
      end

      DADOS: begin
        cnt_clk_d = cnt_prox;
        if (fim_bit) begin
          shift_d[idx_bit_q] = rx_s;
          if (idx_bit_q == IDX_ULTIMO) begin
            estado_d = PARIDADE;
          end else begin
            idx_bit_d = idx_bit_q + 2'd1;
          end
        end
      end

      PARIDADE: begin
        cnt_clk_d = cnt_prox;
        if (fim_bit) begin
          p_rx_d     = rx_s;
          esperado_d = calc_paridade(shift_q, IMPAR);
          estado_d   = PARADA;
        end
      end

      PARADA: begin
        cnt_clk_d = cnt_prox;
        if (fim_bit) begin
          // Bad frames still deliver their data. The flags say what was wrong.
          dado_d          = shift_q;
          erro_paridade_d = (p_rx_q != esperado_q);
          erro_quadro_d   = ~rx_s;
          valido_d        = 1'b1;
          estado_d        = OCIOSO;
        end
      end

      default: begin
        estado_d  = OCIOSO;
        cnt_clk_d = '0;
      end
    endcase

    ocupado_d = (estado_d != OCIOSO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q        <= OCIOSO;
      cnt_clk_q       <= '0;
      idx_bit_q       <= '0;
      shift_q         <= '0;
      p_rx_q          <= 1'b0;
      esperado_q      <= 1'b0;
      dado_q          <= '0;
      valido_q        <= 1'b0;
      erro_paridade_q <= 1'b0;
      erro_quadro_q   <= 1'b0;
      ocupado_q       <= 1'b0;
    end else begin
      estado_q        <= estado_d;
      cnt_clk_q       <= cnt_clk_d;
      idx_bit_q       <= idx_bit_d;
      shift_q         <= shift_d;
      p_rx_q          <= p_rx_d;
      esperado_q      <= esperado_d;
      dado_q          <= dado_d;
      valido_q        <= valido_d;
      erro_paridade_q <= erro_paridade_d;
      erro_quadro_q   <= erro_quadro_d;
      ocupado_q       <= ocupado_d;
    end
  end

  assign dado          = dado_q;
  assign valido        = valido_q;
  assign erro_paridade = erro_paridade_q;
  assign erro_quadro   = erro_quadro_q;
  assign ocupado       = ocupado_q;

endmodule

// File: tb/tb_receptor_paridade_serial.sv
module tb_receptor_paridade_serial;

  localparam int C       = 4;
  localparam int IMPAR   = 0;
  localparam int EXP_LAT = 2 + C / 2 + 6 * C;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [3:0] dado;
  logic       valido;
  logic       erro_paridade;
  logic       erro_quadro;
  logic       ocupado;

  receptor_paridade_serial #(
    .CLKS_POR_BIT   (C),
    .PARIDADE_IMPAR (IMPAR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .dado          (dado),
    .valido        (valido),
    .erro_paridade (erro_paridade),
    .erro_quadro   (erro_quadro),
    .ocupado       (ocupado)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  // Entry layout: {erro_paridade, erro_quadro, dado}
  logic [5:0] exp_q[$];
  int         t_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] ultimo_dado = 4'h0;

  task automatic check(input string nome, input logic [31:0] atual,
                       input logic [31:0] esperado);
    n_checks++;
    if (atual !== esperado) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  // Reference model: parity from a count of ones. The parity bit and stop bit
  // sent on the line decide the expected flags.
  function automatic logic [5:0] modelo(input logic [3:0] d, input logic p,
                                        input logic stop);
    int   uns;
    logic par_certa;
    uns       = $countones(d);
    par_certa = ((uns % 2) == 1);
    if (IMPAR != 0) par_certa = ~par_certa;
    return {(p != par_certa), (stop == 1'b0), d};
  endfunction

  function automatic logic par_correta(input logic [3:0] d);
    int uns;
    uns = $countones(d);
    return (((uns % 2) == 1) ? 1'b1 : 1'b0) ^ (IMPAR != 0);
  endfunction

  // Monitor: every valido pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (valido === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL valido_inesperado: got valido=1 expected no pulse (t=%0t)", $time);
      end else begin
        logic [5:0] e;
        int         t0;
        e  = exp_q.pop_front();
        t0 = t_q.pop_front();
        check("dado", dado, e[3:0]);
        check("erro_paridade", erro_paridade, e[5]);
        check("erro_quadro", erro_quadro, e[4]);
        n_checks++;
        if ((cyc - t0) < EXP_LAT - 1 || (cyc - t0) > EXP_LAT + 1) begin
          n_fail++;
          $display("FAIL latencia: got %0d expected %0d +/-1", cyc - t0, EXP_LAT);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called aligned to negedge)
  // ---------------------------------------------------------------------------
  task automatic bit_out(input logic v);
    rx = v;
    repeat (C) @(negedge clk);
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input logic stop);
    exp_q.push_back(modelo(d, p, stop));
    t_q.push_back(cyc);
    ultimo_dado = d;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(d[i]);
    bit_out(p);
    bit_out(stop);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string nome);
    check({nome, "_dado"}, dado, 4'h0);
    check({nome, "_valido"}, valido, 1'b0);
    check({nome, "_erro_paridade"}, erro_paridade, 1'b0);
    check({nome, "_erro_quadro"}, erro_quadro, 1'b0);
    check({nome, "_ocupado"}, ocupado, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Idle line: nothing happens.
    idle(100);
    check_zero("ocioso");

    // Directed frames.
    send_frame(4'hB, 1'b1, 1'b1);
    idle(4);
    send_frame(4'h6, 1'b1, 1'b1);
    idle(4);
    send_frame(4'h0, 1'b0, 1'b0);
    idle(10);

    // One-cycle glitch must be rejected.
    rx = 1'b0;
    @(negedge clk);
    idle(20);
    check("glitch_ocupado", ocupado, 1'b0);

    // All nibbles back-to-back with correct parity.
    for (int n = 0; n < 16; n++) begin
      logic [3:0] d;
      d = 4'(n);
      send_frame(d, par_correta(d), 1'b1);
    end
    idle(10);

    // Reset in the middle of DADOS: partial frame is dropped.
    rx = 1'b0;
    repeat (C) @(negedge clk);
    bit_out(1'b1);
    bit_out(1'b0);
    check("meio_quadro_ocupado", ocupado, 1'b1);
    rst_n = 1'b0;
    #1;
    check_zero("reset_meio");
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    send_frame(4'h5, par_correta(4'h5), 1'b1);
    idle(4);

    // Random frames, with some parity and framing errors.
    for (int n = 0; n < 24; n++) begin
      logic [3:0] d;
      logic       p;
      logic       s;
      d = 4'($urandom_range(0, 15));
      p = par_correta(d);
      if ($urandom_range(0, 3) == 0) p = ~p;
      s = ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1;
      send_frame(d, p, s);
      // A low stop bit needs idle time so it is not mistaken for a new start.
      idle(s ? $urandom_range(0, 3) : 10);
    end

    // Drain the scoreboard, with a bound.
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("fila_vazia", exp_q.size(), 0);
    idle(20);
    check("dado_mantido", dado, ultimo_dado);
    check("fim_ocupado", ocupado, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
